// File: rtl/wf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wf_sequencer
// Brief    : Waveform table playback from a 1-cycle-latency RAM port. Supports
//            loop, one-shot and repeat-N modes with half and wrap interrupts.
//            Optional macro WF_SEQ_HOLD_LAST_EN keeps the last sample visible
//            after DONE or abort.
// Revision : 1.0 - initial release
// ============================================================================
module wf_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W:0]   i_length,
    input  logic [ADDR_W-1:0] i_half,
    input  logic [15:0]       i_repeat,
    input  logic              i_tick,
    output logic              o_ce,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_valid,
    output logic              o_int_half,
    output logic              o_int_wrap,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic              o_cfg_err,
    output logic [CNT_W-1:0]  o_pass_count,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   c_max_len      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_len_one      = 1;
    localparam logic [ADDR_W-1:0] c_addr_one     = 1;
    localparam logic [CNT_W-1:0]  c_cnt_one      = 1;
    localparam logic [1:0]        c_mode_oneshot = 2'd1;
    localparam logic [1:0]        c_mode_repeat  = 2'd2;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_start_d;
    logic [1:0]          r_mode;
    logic [ADDR_W:0]     r_length;
    logic [ADDR_W-1:0]   r_half;
    logic [15:0]         r_repeat;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_prefetch;
    logic [DATA_W-1:0]   r_sample;
    logic                r_valid;
    logic                r_int_half;
    logic                r_int_wrap;
    logic                r_overrun;
    logic                r_cfg_err;
    logic                r_done_dly;
    logic [CNT_W-1:0]    r_pass_count;

    logic                w_start_rise;
    logic                w_cfg_bad;
    logic                w_go;
    logic                w_last;
    logic                w_final;
    logic                w_emit;
    logic                w_abort;
    logic [15:0]         w_rep;
    logic [CNT_W-1:0]    w_pass_inc;

    always_comb begin
        w_start_rise = i_start & ~r_start_d;
        w_cfg_bad    = (i_length == '0) || (i_length > c_max_len);
        w_go         = (r_state == S_IDLE) && w_start_rise && !w_cfg_bad;
        w_last       = ({1'b0, r_addr} == (r_length - c_len_one));
        w_rep        = (r_repeat == 16'd0) ? 16'd1 : r_repeat;
        w_pass_inc   = r_pass_count + c_cnt_one;
        w_final      = (r_mode == c_mode_oneshot) ||
                       ((r_mode == c_mode_repeat) && (w_pass_inc == CNT_W'(w_rep)));
        // Dropping i_start beats a same-cycle tick.
        w_emit       = (r_state == S_RUN) && i_tick && i_start;
        w_abort      = !i_start && ((r_state == S_FETCH) || (r_state == S_WAIT) ||
                                    (r_state == S_RUN));
    end

    always_comb begin
        w_state_next = r_state;
        o_ce         = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                o_ce         = 1'b1;
                o_busy       = 1'b1;
                w_state_next = i_start ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                o_busy       = 1'b1;
                w_state_next = i_start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (!i_start)    w_state_next = S_IDLE;
                else if (i_tick) w_state_next = (w_last && w_final) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                if (!i_start) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_start_d    <= 1'b0;
            r_mode       <= '0;
            r_length     <= '0;
            r_half       <= '0;
            r_repeat     <= '0;
            r_addr       <= '0;
            r_prefetch   <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_int_half   <= 1'b0;
            r_int_wrap   <= 1'b0;
            r_overrun    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_done_dly   <= 1'b0;
            r_pass_count <= '0;
        end else if (i_clr) begin
            r_state      <= S_IDLE;
            r_start_d    <= 1'b0;
            r_mode       <= '0;
            r_length     <= '0;
            r_half       <= '0;
            r_repeat     <= '0;
            r_addr       <= '0;
            r_prefetch   <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_int_half   <= 1'b0;
            r_int_wrap   <= 1'b0;
            r_overrun    <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_done_dly   <= 1'b0;
            r_pass_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_start_d  <= i_start;
            r_valid    <= w_emit;
            r_int_half <= w_emit && (r_addr == r_half);
            r_int_wrap <= w_emit && w_last;
            // Delays o_done one cycle so it follows the final sample pulse.
            r_done_dly <= (r_state == S_DONE);

            if (!i_start) begin
                r_cfg_err <= 1'b0;
            end else if ((r_state == S_IDLE) && w_start_rise) begin
                r_cfg_err <= w_cfg_bad;
            end

            if (w_go) begin
                r_mode       <= i_mode;
                r_length     <= i_length;
                r_half       <= i_half;
                r_repeat     <= i_repeat;
                r_addr       <= '0;
                r_pass_count <= '0;
                r_overrun    <= 1'b0;
            end else if (((r_state == S_FETCH) || (r_state == S_WAIT)) && i_tick) begin
                r_overrun <= 1'b1;
            end

            if (r_state == S_WAIT) begin
                r_prefetch <= i_ram_dout;
            end

            if (w_emit) begin
                if (w_last) begin
                    r_addr       <= '0;
                    r_pass_count <= w_pass_inc;
                end else begin
                    r_addr <= r_addr + c_addr_one;
                end
            end

            if (w_emit) begin
                r_sample <= r_prefetch;
            end else if (w_go) begin
                r_sample <= '0;
            end
`ifndef WF_SEQ_HOLD_LAST_EN
            else if (w_abort || (r_state == S_DONE)) begin
                r_sample <= '0;
            end
`endif
        end
    end

    assign o_addr         = r_addr;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;
    assign o_int_half     = r_int_half;
    assign o_int_wrap     = r_int_wrap;
    assign o_done         = (r_state == S_DONE) && r_done_dly;
    assign o_overrun      = r_overrun;
    assign o_cfg_err      = r_cfg_err & i_start;
    assign o_pass_count   = r_pass_count;
    assign o_state        = r_state;

endmodule
`default_nettype wire
